// File: rtl/interp_pkg.sv
// Shared types and constants for the linear-interpolation upsampler.
// Build option: LINEAR_INTERP_ROUND_EN selects round-half-up interpolation in interp_datapath.
package interp_pkg;

    localparam int unsigned SampleW     = 16;
    localparam int unsigned RatioLogMin = 1;
    localparam int unsigned RatioLogMax = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StHold
    } state_e;

endpackage

// File: rtl/interp_datapath.sv
// Combinational interpolator: y = p0 + ((p1 - p0) * k) >>> G_RATIO_LOG.
// LINEAR_INTERP_ROUND_EN adds half an LSB of the shift before flooring (round half up).
module interp_datapath
    import interp_pkg::*;
#(
    parameter int unsigned G_RATIO_LOG = 2
) (
    input  logic signed [SampleW-1:0]     p0,
    input  logic signed [SampleW-1:0]     p1,
    input  logic        [G_RATIO_LOG-1:0] k,
    output logic signed [SampleW-1:0]     y
);

    localparam int unsigned ProdW = SampleW + 1 + G_RATIO_LOG;

    logic signed [SampleW:0]  diff;
    logic signed [ProdW-1:0]  diff_x;
    logic signed [ProdW-1:0]  k_x;
    logic signed [ProdW-1:0]  prod;
    logic signed [ProdW-1:0]  biased;
    logic signed [ProdW-1:0]  shifted;
    logic signed [ProdW-1:0]  sum;
    logic                     unused_sum_msb;

    always_comb begin
        diff   = {p1[SampleW-1], p1} - {p0[SampleW-1], p0};
        diff_x = {{G_RATIO_LOG{diff[SampleW]}}, diff};
        k_x    = {{(ProdW - G_RATIO_LOG){1'b0}}, k};
        prod   = diff_x * k_x;
`ifdef LINEAR_INTERP_ROUND_EN
        biased = prod + (ProdW'(1) << (G_RATIO_LOG - 1));
`else
        biased = prod;
`endif
        shifted = biased >>> G_RATIO_LOG;
        // Result always lies between p0 and p1, so the low bits are exact.
        sum     = {{(ProdW - SampleW){p0[SampleW-1]}}, p0} + shifted;
        y       = sum[SampleW-1:0];
    end

    assign unused_sum_msb = ^sum[ProdW-1:SampleW];

endmodule

// File: rtl/linear_interp_upsampler.sv
// Upsamples by 2^G_RATIO_LOG using linear interpolation between consecutive input samples.
// Build option: LINEAR_INTERP_ROUND_EN (rounding in interp_datapath).
module linear_interp_upsampler
    import interp_pkg::*;
#(
    parameter int unsigned G_RATIO_LOG = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Flush,
    input  logic signed [SampleW-1:0] InData,
    input  logic                      InValid,
    output logic                      InReady,
    output logic signed [SampleW-1:0] OutData,
    output logic                      OutValid,
    output logic                      Underrun
);

    if (G_RATIO_LOG < RatioLogMin || G_RATIO_LOG > RatioLogMax) begin : gen_param_err
        $error("G_RATIO_LOG out of range");
    end

    localparam logic [G_RATIO_LOG-1:0] KLast = '1;

    state_e                   state_q, state_d;
    logic signed [SampleW-1:0] nxt_q, nxt_d;
    logic                     nxt_full_q, nxt_full_d;
    logic signed [SampleW-1:0] p0_q, p0_d, p1_q, p1_d;
    logic [G_RATIO_LOG-1:0]   k_q, k_d;
    logic signed [SampleW-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     underrun_q, underrun_d;
    logic                     accept, consume;
    logic signed [SampleW-1:0] y;

    interp_datapath #(
        .G_RATIO_LOG (G_RATIO_LOG)
    ) u_datapath (
        .p0 (p0_q),
        .p1 (p1_q),
        .k  (k_q),
        .y  (y)
    );

    assign InReady  = ~nxt_full_q;
    assign accept   = InValid & ~nxt_full_q;
    assign OutData  = out_data_q;
    assign OutValid = out_valid_q;
    assign Underrun = underrun_q;

    always_comb begin
        state_d     = state_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        k_d         = k_q;
        consume     = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        underrun_d  = underrun_q;

        unique case (state_q)
            StIdle: begin
                if (nxt_full_q) begin
                    p1_d    = nxt_q;
                    consume = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (nxt_full_q) begin
                    p0_d    = p1_q;
                    p1_d    = nxt_q;
                    k_d     = '0;
                    consume = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                out_valid_d = 1'b1;
                out_data_d  = y;
                k_d         = k_q + 1'b1;
                if (k_q == KLast) begin
                    if (nxt_full_q) begin
                        p0_d    = p1_q;
                        p1_d    = nxt_q;
                        consume = 1'b1;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                out_valid_d = 1'b1;
                out_data_d  = p1_q;
                underrun_d  = 1'b1;
                if (nxt_full_q) begin
                    p0_d    = p1_q;
                    p1_d    = nxt_q;
                    k_d     = '0;
                    consume = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase

        nxt_full_d = (nxt_full_q & ~consume) | accept;
        nxt_d      = accept ? InData : nxt_q;

        // Flush overrides every transition above, including a same-cycle accept.
        if (Flush) begin
            state_d     = StIdle;
            nxt_full_d  = 1'b0;
            p0_d        = '0;
            p1_d        = '0;
            k_d         = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            underrun_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            nxt_q       <= '0;
            nxt_full_q  <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            k_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            nxt_full_q  <= nxt_full_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_linear_interp_upsampler.sv
// Directed bench for linear_interp_upsampler: vector table at G_RATIO_LOG=2 plus a
// G_RATIO_LOG=1 streaming instance; expectations follow LINEAR_INTERP_ROUND_EN.
module tb_linear_interp_upsampler;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               underrun;

    logic               flush1;
    logic signed [15:0] in_data1;
    logic               in_valid1;
    logic               in_ready1;
    logic signed [15:0] out_data1;
    logic               out_valid1;
    logic               underrun1;

    always #5 clk = ~clk;

    linear_interp_upsampler #(.G_RATIO_LOG(2)) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .Flush    (flush),
        .InData   (in_data),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .OutData  (out_data),
        .OutValid (out_valid),
        .Underrun (underrun)
    );

    linear_interp_upsampler #(.G_RATIO_LOG(1)) dut1 (
        .Clk      (clk),
        .Reset    (rst_n),
        .Flush    (flush1),
        .InData   (in_data1),
        .InValid  (in_valid1),
        .InReady  (in_ready1),
        .OutData  (out_data1),
        .OutValid (out_valid1),
        .Underrun (underrun1)
    );

    typedef struct {
        int n_in;
        int din[4];
        int n_out;
        int dout[8];
        int ur;
    } vec_t;

    vec_t vecs[5];
    int   q_data[$];
    int   q_ur[$];
    int   q1_data[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            q_data.push_back(int'(out_data));
            q_ur.push_back(int'(underrun));
        end
        if (out_valid1) q1_data.push_back(int'(out_data1));
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int x);
        int c;
        in_data  = 16'(x);
        in_valid = 1'b1;
        c = 0;
        while (!in_ready && c < 50) begin
            tick();
            c++;
        end
        if (c >= 50) check("feed_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int c;
        c = 0;
        while (q_data.size() < n && c < 200) begin
            tick();
            c++;
        end
        check("output_count", (q_data.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_outvalid"}, int'(out_valid), 0);
        check({tag, "_outdata"}, int'(out_data), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
        check({tag, "_inready"}, int'(in_ready), 1);
    endtask

    task automatic expect_seq(input string tag, input int e0, input int e1, input int e2,
                              input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        wait_outs(4);
        for (int j = 0; j < 4; j++) begin
            if (j < q_data.size()) check($sformatf("%s_out%0d", tag, j), q_data[j], e[j]);
        end
        if (q_ur.size() >= 4) check({tag, "_underrun"}, q_ur[3], 0);
    endtask

    initial begin
        int toggles;
        logic prev_rdy;
        logic rdy;

        vecs[0] = '{3, '{0, 400, 800, 0}, 8, '{0, 100, 200, 300, 400, 500, 600, 700}, 0};
        vecs[1] = '{2, '{100, -100, 0, 0}, 6, '{100, 50, 0, -50, -100, -100, 0, 0}, 1};
`ifdef LINEAR_INTERP_ROUND_EN
        vecs[2] = '{2, '{0, 3, 0, 0}, 4, '{0, 1, 2, 2, 0, 0, 0, 0}, 0};
        vecs[3] = '{2, '{-32768, 32767, 0, 0}, 5,
                    '{-32768, -16384, 0, 16383, 32767, 0, 0, 0}, 1};
        vecs[4] = '{2, '{32767, -32768, 0, 0}, 5,
                    '{32767, 16383, 0, -16384, -32768, 0, 0, 0}, 1};
`else
        vecs[2] = '{2, '{0, 3, 0, 0}, 4, '{0, 0, 1, 2, 0, 0, 0, 0}, 0};
        vecs[3] = '{2, '{-32768, 32767, 0, 0}, 5,
                    '{-32768, -16385, -1, 16383, 32767, 0, 0, 0}, 1};
        vecs[4] = '{2, '{32767, -32768, 0, 0}, 5,
                    '{32767, 16383, -1, -16385, -32768, 0, 0, 0}, 1};
`endif

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        flush1    = 1'b0;
        in_data1  = '0;
        in_valid1 = 1'b0;
        tick();
        tick();
        check_cleared("reset");
        rst_n = 1'b1;
        tick();

        // Table-driven vectors, each starting from a flushed block.
        for (int v = 0; v < 5; v++) begin
            do_flush();
            q_data.delete();
            q_ur.delete();
            for (int i = 0; i < vecs[v].n_in; i++) feed(vecs[v].din[i]);
            wait_outs(vecs[v].n_out);
            for (int j = 0; j < vecs[v].n_out; j++) begin
                if (j < q_data.size())
                    check($sformatf("v%0d_out%0d", v, j), q_data[j], vecs[v].dout[j]);
            end
            if (q_ur.size() >= vecs[v].n_out)
                check($sformatf("v%0d_underrun", v), q_ur[vecs[v].n_out-1], vecs[v].ur);
        end

        // Reset mid-RUN with Underrun already set from the HOLD above.
        feed(1000);
        q_data.delete();
        q_ur.delete();
        wait_outs(2);
        rst_n = 1'b0;
        #1;
        check_cleared("async_reset");
        tick();
        check_cleared("reset_next");
        rst_n = 1'b1;
        q_data.delete();
        q_ur.delete();
        feed(40);
        feed(80);
        expect_seq("after_reset", 40, 50, 60, 70);

        // Flush mid-RUN.
        feed(2000);
        q_data.delete();
        q_ur.delete();
        wait_outs(2);
        do_flush();
        check_cleared("flush");
        q_data.delete();
        q_ur.delete();
        feed(8);
        feed(16);
        expect_seq("after_flush", 8, 10, 12, 14);

        // Ratio 2 with InValid held high and a ramp of step 2.
        in_data1  = 16'sd10;
        in_valid1 = 1'b1;
        toggles   = 0;
        prev_rdy  = in_ready1;
        for (int c = 0; c < 40; c++) begin
            rdy = in_ready1;
            if (rdy != prev_rdy) toggles++;
            prev_rdy = rdy;
            tick();
            if (rdy) in_data1 = in_data1 + 16'sd2;
        end
        in_valid1 = 1'b0;
        check("r2_output_count", (q1_data.size() >= 16) ? 1 : 0, 1);
        for (int j = 0; j < 16; j++) begin
            if (j < q1_data.size()) check($sformatf("r2_out%0d", j), q1_data[j], 10 + j);
        end
        check("r2_underrun", int'(underrun1), 0);
        check("r2_ready_toggles", (toggles >= 20) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
